// File: rtl/key_debounce_pkg.sv
// Shared constants and helpers for the piano key conditioning path.
package key_debounce_pkg;

  localparam int unsigned CLK_HZ          = 2_080_000;
  // 10 ms at CLK_HZ, and the narrowest counter that can hold it.
  localparam int unsigned DEBOUNCE_STABLE = 20_800;
  localparam int unsigned DEBOUNCE_CW     = 15;
  localparam int unsigned NUM_KEYS        = 4;

  typedef logic [NUM_KEYS:1] key_vec_t;

  // Map pin levels onto "1 = pressed" regardless of button wiring.
  function automatic key_vec_t apply_polarity(input key_vec_t pins, input bit active_low);
    return active_low ? ~pins : pins;
  endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// Single-bit debouncer: two-flop synchronizer, stability counter,
// debounced level and registered press/release pulses.
module debounce_chan
  import key_debounce_pkg::*;
#(
  parameter int unsigned stable = DEBOUNCE_STABLE,
  parameter int unsigned cw     = DEBOUNCE_CW
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,      // already polarity-corrected, still asynchronous
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam logic [cw-1:0] LAST = cw'(stable - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic          press_q, release_q;
  logic          accept;

  // Next-state for counter and level: count while disagreeing, accept on the last count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = '0;
    level_d = level_q;
    accept  = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == LAST) begin
        accept  = 1'b1;
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + cw'(1);
      end
    end
  end

  // State registers; pulses are registered so they line up with the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so s2_q takes the old s1_q, forming a real two-stage synchronizer.
      s1_q      <= pin_i;
      s2_q      <= s1_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= accept & s2_q;
      release_q <= accept & ~s2_q;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Four-channel pushbutton conditioner feeding the piano note selector.
// Applies pin polarity and runs one independent debouncer per key.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned stable     = DEBOUNCE_STABLE,
  parameter int unsigned cw         = DEBOUNCE_CW,
  parameter bit          active_low = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [4:1]     raw_i,
  output logic           key1_o,
  output logic           key2_o,
  output logic           key3_o,
  output logic           key4_o,
  output logic [4:1]     press_o,
  output logic [4:1]     release_o
);

  key_vec_t pressed;
  key_vec_t level;

  assign pressed = apply_polarity(raw_i, active_low);

  // One debouncer per key; channels share nothing but clock and reset.
  for (genvar i = 1; i <= 4; i++) begin : g_chan
    debounce_chan #(
      .stable (stable),
      .cw     (cw)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .pin_i     (pressed[i]),
      .level_o   (level[i]),
      .press_o   (press_o[i]),
      .release_o (release_o[i])
    );
  end

  assign key1_o = level[1];
  assign key2_o = level[2];
  assign key3_o = level[3];
  assign key4_o = level[4];

endmodule
